// File: rtl/mos6502_bus_pkg.sv
// Shared types, widths and address-decode helpers for the 6502 bus responder.
package mos6502_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StDrive,
    StWrite
  } bus_state_e;

  // Trace entry is {PC[15:0], opcode[7:0]}.
  localparam int unsigned TRACE_W = 24;

  // RAM occupies $0000 .. 2^ram_aw - 1.
  function automatic logic is_ram_hit(input logic [15:0] ab, input int unsigned ram_aw);
    return 32'(ab) < (32'd1 << ram_aw);
  endfunction

  // ROM occupies the top 2^rom_aw bytes, ending at $FFFF.
  function automatic logic is_rom_hit(input logic [15:0] ab, input int unsigned rom_aw);
    return 32'(ab) >= (32'd65536 - (32'd1 << rom_aw));
  endfunction

endpackage

// File: rtl/mos6502_bus_responder_trace_fifo.sv
// Synchronous trace FIFO; a pop in the same cycle frees a slot for a push while full.
module trace_fifo
  import mos6502_bus_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [TRACE_W-1:0] push_data_i,
  output logic               push_accept_o,
  output logic               full_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [TRACE_W-1:0] data_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PtrW:0]        wr_ptr_q, rd_ptr_q;
  logic [TRACE_W-1:0]   mem_q [Depth];
  logic                 empty, pop;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full_o = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                  (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign valid_o       = ~empty;
  assign pop           = valid_o & ready_i;
  assign push_accept_o = push_i & (~full_o | pop);
  assign data_o        = empty ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];

  // Pointer update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_accept_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)           rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Entry storage, not reset.
  always_ff @(posedge clk_i) begin
    if (push_accept_o) mem_q[wr_ptr_q[PtrW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/mos6502_bus_responder.sv
// Memory-side responder for the 6502 core: RAM/ROM service, write commit and opcode trace.
module mos6502_bus_responder
  import mos6502_bus_pkg::*;
#(
  parameter int unsigned RAM_AW      = 10,
  parameter int unsigned ROM_AW      = 8,
  parameter int unsigned TRACE_DEPTH = 8
) (
  input  logic               CLK_50MHZ,
  input  logic               RESET_N,
  input  logic [15:0]        CPU_AB,
  input  logic               CPU_RW,
  input  logic               CPU_SYNC,
  input  logic               CPU_PHI2,
  input  logic [7:0]         CPU_DB_IN,
  output logic [7:0]         CPU_DB_OUT,
  output logic               CPU_DB_OE,
  input  logic               ROM_WE,
  input  logic [ROM_AW-1:0]  ROM_WADDR,
  input  logic [7:0]         ROM_WDATA,
  output logic               TRACE_VALID,
  input  logic               TRACE_READY,
  output logic [TRACE_W-1:0] TRACE_DATA,
  output logic               TRACE_OVF,
  output logic               BUS_ERR
);

  bus_state_e state_q, state_d;

  logic        phi2_q, rise, fall;
  logic [15:0] ab_q;
  logic        sync_q, rom_sel_q;
  logic [7:0]  wdata_q, ram_rd_q, rom_rd_q;
  logic        oe_q, bus_err_q, ovf_q;

  logic [7:0]  ram_q [2**RAM_AW];
  logic [7:0]  rom_q [2**ROM_AW];

  logic        dec_ram, dec_rom, dec_mapped, in_decode;
  logic        ram_we, trace_push, push_accept, fifo_full;

  assign rise = CPU_PHI2 & ~phi2_q;
  assign fall = ~CPU_PHI2 & phi2_q;

  assign dec_ram    = is_ram_hit(CPU_AB, RAM_AW);
  assign dec_rom    = is_rom_hit(CPU_AB, ROM_AW);
  assign dec_mapped = dec_ram | dec_rom;
  assign in_decode  = (state_q == StDecode);

  assign ram_we     = (state_q == StWrite) & fall & is_ram_hit(ab_q, RAM_AW);
  assign trace_push = (state_q == StDrive) & fall & sync_q;

  // Read data is only presented while driving; otherwise the bus reads as zero.
  assign CPU_DB_OUT = oe_q ? (rom_sel_q ? rom_rd_q : ram_rd_q) : 8'h00;
  assign CPU_DB_OE  = oe_q;
  assign BUS_ERR    = bus_err_q;
  assign TRACE_OVF  = ovf_q;

  // Bus-cycle sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (rise) state_d = StDecode;
      StDecode: begin
        if (fall)        state_d = StIdle;  // short cycle
        else if (CPU_RW) state_d = StDrive;
        else             state_d = StWrite;
      end
      StDrive:  if (fall) state_d = StIdle;
      StWrite:  if (fall) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      phi2_q    <= 1'b0;
      ab_q      <= '0;
      sync_q    <= 1'b0;
      rom_sel_q <= 1'b0;
      wdata_q   <= '0;
      oe_q      <= 1'b0;
      bus_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phi2_q    <= CPU_PHI2;
      bus_err_q <= in_decode & (fall | ~dec_mapped);
      if (in_decode) begin
        ab_q      <= CPU_AB;
        sync_q    <= CPU_SYNC;
        rom_sel_q <= dec_rom;
        oe_q      <= ~fall & CPU_RW & dec_mapped;
      end else if (fall) begin
        oe_q <= 1'b0;
      end
      if ((state_q == StWrite) && CPU_PHI2) wdata_q <= CPU_DB_IN;
      if (trace_push && !push_accept) ovf_q <= 1'b1;
    end
  end

  // Memory arrays: synchronous read captured in DECODE, RAM commit on the write fall.
  always_ff @(posedge CLK_50MHZ) begin
    if (in_decode) begin
      ram_rd_q <= ram_q[CPU_AB[RAM_AW-1:0]];
      rom_rd_q <= rom_q[CPU_AB[ROM_AW-1:0]];
    end
    if (ram_we) ram_q[ab_q[RAM_AW-1:0]] <= wdata_q;
    if (ROM_WE) rom_q[ROM_WADDR] <= ROM_WDATA;
  end

  trace_fifo #(
    .Depth(TRACE_DEPTH)
  ) u_trace_fifo (
    .clk_i        (CLK_50MHZ),
    .rst_ni       (RESET_N),
    .push_i       (trace_push),
    .push_data_i  ({ab_q, CPU_DB_OUT}),
    .push_accept_o(push_accept),
    .full_o       (fifo_full),
    .valid_o      (TRACE_VALID),
    .ready_i      (TRACE_READY),
    .data_o       (TRACE_DATA)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_mos6502_bus_responder.sv
// Randomized bench for mos6502_bus_responder against a memory/queue reference model.
module tb_mos6502_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ab;
  logic        rw, sync, phi2;
  logic [7:0]  db_in, db_out;
  logic        db_oe;
  logic        rom_we;
  logic [7:0]  rom_waddr, rom_wdata;
  logic        trace_valid, trace_ready;
  logic [23:0] trace_data;
  logic        trace_ovf, bus_err;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;

  // Reference model state.
  logic [7:0]  ram_m [1024];
  logic [7:0]  rom_m [256];
  logic [23:0] trace_m [$];
  logic        ovf_m;

  always #5 clk = ~clk;

  mos6502_bus_responder #(
    .RAM_AW(10),
    .ROM_AW(8),
    .TRACE_DEPTH(8)
  ) dut (
    .CLK_50MHZ  (clk),
    .RESET_N    (rst_n),
    .CPU_AB     (ab),
    .CPU_RW     (rw),
    .CPU_SYNC   (sync),
    .CPU_PHI2   (phi2),
    .CPU_DB_IN  (db_in),
    .CPU_DB_OUT (db_out),
    .CPU_DB_OE  (db_oe),
    .ROM_WE     (rom_we),
    .ROM_WADDR  (rom_waddr),
    .ROM_WDATA  (rom_wdata),
    .TRACE_VALID(trace_valid),
    .TRACE_READY(trace_ready),
    .TRACE_DATA (trace_data),
    .TRACE_OVF  (trace_ovf),
    .BUS_ERR    (bus_err)
  );

  // BUS_ERR pulses are one clock wide; count them away from the active edge.
  always @(negedge clk) if (bus_err === 1'b1) err_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_ram(input logic [15:0] a);
    return a < 16'h0400;
  endfunction

  function automatic logic is_rom(input logic [15:0] a);
    return a >= 16'hFF00;
  endfunction

  function automatic logic [7:0] model_rd(input logic [15:0] a);
    if (is_ram(a)) return ram_m[a[9:0]];
    if (is_rom(a)) return rom_m[a[7:0]];
    return 8'h00;
  endfunction

  task automatic check_reset_values();
    check_eq("rst_db_out", 32'(db_out), 32'h0);
    check_eq("rst_db_oe", 32'(db_oe), 32'h0);
    check_eq("rst_valid", 32'(trace_valid), 32'h0);
    check_eq("rst_data", 32'(trace_data), 32'h0);
    check_eq("rst_ovf", 32'(trace_ovf), 32'h0);
    check_eq("rst_bus_err", 32'(bus_err), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    phi2  = 1'b0;
    trace_ready = 1'b0;
    #2;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    trace_m.delete();
    ovf_m = 1'b0;
  endtask

  task automatic rom_load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    rom_we = 1'b1;
    rom_waddr = a;
    rom_wdata = d;
    @(negedge clk);
    rom_we = 1'b0;
    rom_m[a] = d;
  endtask

  // One bus cycle with PHI2 high for hi clocks (hi >= 3 serviced, hi == 1 short).
  task automatic bus_cycle(input logic [15:0] a, input logic r, input logic s,
                           input logic [7:0] wd, input int hi, input logic rdy_at_fall);
    int          err0;
    logic        mapped;
    logic [7:0]  exp_rd;
    err0   = err_cnt;
    mapped = is_ram(a) || is_rom(a);
    exp_rd = model_rd(a);
    @(negedge clk);
    ab = a; rw = r; sync = s; db_in = wd; phi2 = 1'b1;
    for (int i = 1; i <= hi; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) check_eq("oe_before_decode", 32'(db_oe), 32'h0);
      if (i == 2 && hi >= 3) begin
        check_eq("db_oe", 32'(db_oe), 32'(r && mapped));
        check_eq("db_out", 32'(db_out), (r && mapped) ? 32'(exp_rd) : 32'h0);
      end
    end
    phi2 = 1'b0;
    trace_ready = rdy_at_fall;
    @(posedge clk);
    @(negedge clk);
    trace_ready = 1'b0;
    check_eq("oe_after_fall", 32'(db_oe), 32'h0);
    if (hi >= 3) begin
      if (!r && is_ram(a)) ram_m[a[9:0]] = wd;
      if (rdy_at_fall && trace_m.size() > 0) void'(trace_m.pop_front());
      if (r && s) begin
        if (trace_m.size() < 8) trace_m.push_back({a, exp_rd});
        else ovf_m = 1'b1;
      end
    end else if (rdy_at_fall && trace_m.size() > 0) begin
      void'(trace_m.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("bus_err_pulses", 32'(err_cnt - err0), 32'((!mapped || hi < 3) ? 1 : 0));
  endtask

  task automatic drain();
    int n;
    n = trace_m.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("trace_valid", 32'(trace_valid), 32'h1);
      check_eq("trace_data", 32'(trace_data), 32'(trace_m[0]));
      trace_ready = 1'b1;
      @(posedge clk);
      void'(trace_m.pop_front());
    end
    @(negedge clk);
    trace_ready = 1'b0;
    check_eq("trace_empty", 32'(trace_valid), 32'h0);
  endtask

  initial begin
    logic [15:0] a;
    logic        r, s;
    int          kind, hi;

    rst_n = 1'b0; ab = '0; rw = 1'b1; sync = 1'b0; phi2 = 1'b0; db_in = '0;
    rom_we = 1'b0; rom_waddr = '0; rom_wdata = '0; trace_ready = 1'b0; ovf_m = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // ROM preload including the reset vector; RAM filled through CPU writes.
    for (int i = 0; i < 256; i++) rom_load(8'(i), 8'($urandom));
    rom_load(8'hFC, 8'h00);
    rom_load(8'hFD, 8'h02);
    for (int i = 0; i < 1024; i++) bus_cycle(16'(i), 1'b0, 1'b0, 8'($urandom), 3, 1'b0);

    // Directed cases.
    bus_cycle(16'hFFFC, 1'b1, 1'b0, 8'h00, 4, 1'b0);
    bus_cycle(16'hFFFD, 1'b1, 1'b0, 8'h00, 4, 1'b0);
    bus_cycle(16'h0123, 1'b0, 1'b0, 8'h5A, 3, 1'b0);
    bus_cycle(16'h0123, 1'b1, 1'b0, 8'h00, 3, 1'b0);
    bus_cycle(16'hFF10, 1'b0, 1'b0, 8'h77, 3, 1'b0);
    bus_cycle(16'hFF10, 1'b1, 1'b0, 8'h00, 3, 1'b0);
    bus_cycle(16'h8000, 1'b1, 1'b0, 8'h00, 3, 1'b0);
    bus_cycle(16'h8000, 1'b1, 1'b1, 8'h00, 3, 1'b0);  // unmapped fetch traces opcode 00
    drain();

    // Randomized traffic, drained often enough that the FIFO never fills.
    for (int it = 0; it < 300; it++) begin
      kind = int'($urandom_range(0, 9));
      r    = 1'($urandom);
      hi   = int'($urandom_range(3, 5));
      if (kind <= 3)      a = 16'($urandom_range(0, 16'h03FF));
      else if (kind <= 5) a = 16'hFF00 | 16'($urandom_range(0, 255));
      else if (kind == 6) a = 16'($urandom_range(16'h0400, 16'hFEFF));
      else begin
        a  = 16'($urandom_range(0, 16'h03FF));
        hi = (kind == 7) ? 1 : hi;
      end
      s = r & 1'($urandom);
      bus_cycle(a, r, s, 8'($urandom), hi, 1'b0);
      if (it % 6 == 5) drain();
    end
    drain();
    check_eq("ovf_clear_random", 32'(trace_ovf), 32'(ovf_m));

    // Overflow: nine fetches into an 8-deep FIFO with no reader.
    do_reset();
    for (int i = 0; i < 9; i++) bus_cycle(16'h0200 + 16'(i), 1'b1, 1'b1, 8'h00, 3, 1'b0);
    check_eq("ovf_set", 32'(trace_ovf), 32'h1);
    check_eq("ovf_model", 32'(trace_ovf), 32'(ovf_m));
    check_eq("first_entry_model", 32'(trace_m[0]), {8'h00, 16'h0200, ram_m[10'h200]});
    drain();

    // Full FIFO with a pop on the same edge as the push.
    do_reset();
    for (int i = 0; i < 8; i++) bus_cycle(16'h0300 + 16'(i), 1'b1, 1'b1, 8'h00, 3, 1'b0);
    bus_cycle(16'h0308, 1'b1, 1'b1, 8'h00, 3, 1'b1);
    check_eq("ovf_pop_push", 32'(trace_ovf), 32'h0);
    check_eq("count_pop_push", 32'(trace_m.size()), 32'd8);
    drain();

    // Short write leaves RAM untouched.
    bus_cycle(16'h0300, 1'b0, 1'b0, ~ram_m[10'h300], 1, 1'b0);
    bus_cycle(16'h0300, 1'b1, 1'b0, 8'h00, 3, 1'b0);

    // Reset while driving drops OE without a clock edge.
    @(negedge clk);
    ab = 16'h0123; rw = 1'b1; sync = 1'b0; phi2 = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check_eq("oe_in_drive", 32'(db_oe), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("oe_async_reset", 32'(db_oe), 32'h0);
    phi2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a write discards it.
    ab = 16'h0124; rw = 1'b0; db_in = ~ram_m[10'h124]; phi2 = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    phi2  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_cycle(16'h0124, 1'b1, 1'b0, 8'h00, 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
